// File: rtl/fp_acc_if.sv
// Floating-point format package and the accumulator's stream interface.
// The upstream side is the product stream from fp_mul. The downstream side
// is the dot-product sum together with its element count.
package fp_pkg;
  localparam int FPExpWidth  = 8;
  localparam int FPMantWidth = 7;

  // Fields are {sgn, exp, mant}. The leading one is hidden and the
  // exponent bias is 2^(FPExpWidth-1).
  typedef struct packed {
    logic                   sgn;
    logic [FPExpWidth-1:0]  exp;
    logic [FPMantWidth-1:0] mant;
  } fp_t;
endpackage

interface fp_acc_if #(parameter int CntWidth = 8);
  import fp_pkg::*;

  fp_t                 prod;
  logic                prod_valid;
  logic                prod_last;
  logic                prod_ready;
  fp_t                 sum;
  logic [CntWidth-1:0] sum_cnt;
  logic                sum_valid;
  logic                sum_ready;

  modport master (
    output prod, prod_valid, prod_last, sum_ready,
    input  prod_ready, sum, sum_cnt, sum_valid
  );

  modport slave (
    input  prod, prod_valid, prod_last, sum_ready,
    output prod_ready, sum, sum_cnt, sum_valid
  );
endinterface

// File: rtl/fp_acc.sv
// Streaming FP accumulator. It sums one vector of products, ended by the
// last flag, into a single fp_t value. It then holds that sum until the
// downstream side takes it. The adder is single-cycle and truncating, and
// it sits directly in the accumulator feedback path.
module fp_acc
  import fp_pkg::*;
#(
  parameter int CntWidth = 8
) (
  input logic      clk_i,
  input logic      rst_ni,
  fp_acc_if.slave  bus
);

  localparam int E      = FPExpWidth;
  localparam int M      = FPMantWidth;
  localparam int ExpMax = 2**E - 1;
  localparam logic [E-1:0] MantW = E'(M);

  typedef enum logic {ACC, OUT} state_e;

  state_e              state_q, state_d;
  fp_t                 acc_q, acc_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                accept;

  // Any value with exp==0 is zero. Its mantissa is dropped so that the
  // result is all-zero.
  function automatic fp_t canon(fp_t x);
    return (x.exp == '0) ? fp_t'('0) : x;
  endfunction

  // Truncating add. The operand with the larger {exp,mant} sets the sign
  // and the starting exponent. The smaller mantissa is right-aligned to it.
  function automatic fp_t fp_add(fp_t a, fp_t b);
    fp_t          l, s, r;
    logic [E-1:0] d;
    logic [M:0]   lm, sm, diff, norm;
    logic [M+1:0] sum;
    int           e, lz;
    logic         found;
    r = '0; l = a; s = b; d = '0; lm = '0; sm = '0; diff = '0; norm = '0;
    sum = '0; e = 0; lz = 0; found = 1'b0;
    if (a.exp == '0) begin
      r = canon(b);
    end else if (b.exp == '0) begin
      r = a;
    end else begin
      if ({b.exp, b.mant} > {a.exp, a.mant}) begin
        l = b;
        s = a;
      end
      d  = l.exp - s.exp;
      lm = {1'b1, l.mant};
      sm = (d > MantW) ? '0 : ({1'b1, s.mant} >> d);
      if (l.sgn == s.sgn) begin
        sum = {1'b0, lm} + {1'b0, sm};
        if (sum[M+1]) begin
          r.mant = sum[M:1];
          e      = int'(l.exp) + 1;
        end else begin
          r.mant = sum[M-1:0];
          e      = int'(l.exp);
        end
      end else begin
        diff = lm - sm;
        for (int i = M; i >= 0; i--) begin
          if (!found) begin
            if (diff[i]) found = 1'b1;
            else         lz = lz + 1;
          end
        end
        norm   = diff << lz;
        r.mant = norm[M-1:0];
        // An exact cancellation goes to +0 through the underflow path.
        e      = (diff == '0) ? 0 : int'(l.exp) - lz;
      end
      r.sgn = l.sgn;
      if (e > ExpMax)  r = {l.sgn, {E{1'b1}}, {M{1'b1}}};
      else if (e <= 0) r = '0;
      else             r.exp = e[E-1:0];
    end
    return r;
  endfunction

  assign accept = (state_q == ACC) && bus.prod_valid;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACC;
    else         state_q <= state_d;
  end

  // Next state: leave ACC when the last element is taken, leave OUT on the sum handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC: if (bus.prod_valid && bus.prod_last) state_d = OUT;
      OUT: if (bus.sum_ready)                   state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Outputs: the sum is visible only while it is being offered downstream
  always_comb begin
    bus.prod_ready = 1'b0;
    bus.sum_valid  = 1'b0;
    bus.sum        = '0;
    bus.sum_cnt    = '0;
    case (state_q)
      ACC: bus.prod_ready = 1'b1;
      OUT: begin
        bus.sum_valid = 1'b1;
        bus.sum       = acc_q;
        bus.sum_cnt   = cnt_q;
      end
      default: ;
    endcase
  end

  // Datapath next state: the first element loads, later elements add; the count saturates
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (accept) begin
      acc_d   = first_q ? canon(bus.prod) : fp_add(acc_q, bus.prod);
      cnt_d   = first_q ? CntWidth'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
      first_d = 1'b0;
    end
    if (state_q == OUT && bus.sum_ready) first_d = 1'b1;
  end

  // Datapath registers; reset drops any partial sum
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_fp_acc.sv
// Directed bench for fp_acc. Expected sums are hand-derived for an 8-bit
// exponent and a 7-bit mantissa with bias 128.
module tb_fp_acc;
  import fp_pkg::*;

  localparam int CW = 8;
  localparam int B  = 2**(FPExpWidth-1);

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   errs   = 0;
  int   checks = 0;

  fp_acc_if #(.CntWidth(CW)) bus();

  fp_acc #(.CntWidth(CW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic fp_t mk(bit s, int e, int m);
    fp_t r;
    r.sgn  = s;
    r.exp  = FPExpWidth'(e);
    r.mant = FPMantWidth'(m);
    return r;
  endfunction

  fp_t ONE, ONE5, TWO;

  task automatic send(input fp_t p, input bit last);
    bus.prod       = p;
    bus.prod_valid = 1'b1;
    bus.prod_last  = last;
    @(posedge clk_i); #1;
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
  endtask

  task automatic drain();
    bus.sum_ready = 1'b1;
    @(posedge clk_i); #1;
    bus.sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b want=0", bus.sum_valid); end
    checks++; if (bus.prod_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got=%b want=1", bus.prod_ready); end
    checks++; if (bus.sum !== fp_t'('0)) begin errs++; $display("FAIL rst_sum got=%h want=0", bus.sum); end
    checks++; if (bus.sum_cnt !== '0) begin errs++; $display("FAIL rst_cnt got=%0d want=0", bus.sum_cnt); end
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    // Reset in the middle of a vector
    send(ONE, 1'b0);
    #2 rst_ni = 1'b0; #1;
    checks++; if (bus.prod_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready got=%b want=1", bus.prod_ready); end
    checks++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid got=%b want=0", bus.sum_valid); end
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    // Reset while a sum is being offered
    send(ONE, 1'b1);
    checks++; if (bus.sum_valid !== 1'b1) begin errs++; $display("FAIL rst_out_pre got=%b want=1", bus.sum_valid); end
    #2 rst_ni = 1'b0; #1;
    checks++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got=%b want=0", bus.sum_valid); end
    checks++; if (bus.sum !== fp_t'('0)) begin errs++; $display("FAIL rst_out_sum got=%h want=0", bus.sum); end
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    // The next vector starts from scratch; a single element passes through exactly
    send(ONE5, 1'b1);
    checks++; if (bus.sum !== ONE5) begin errs++; $display("FAIL rst_scratch_sum got=%h want=%h", bus.sum, ONE5); end
    checks++; if (bus.sum_cnt !== CW'(1)) begin errs++; $display("FAIL rst_scratch_cnt got=%0d want=1", bus.sum_cnt); end
    drain();
  endtask

  task automatic test_basic();
    send(ONE, 1'b0);
    checks++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL basic_early got=%b want=0", bus.sum_valid); end
    send(ONE, 1'b1);
    checks++; if (bus.sum_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b want=1", bus.sum_valid); end
    checks++; if (bus.sum !== mk(0, B+1, 0)) begin errs++; $display("FAIL basic_sum got=%h want=%h", bus.sum, mk(0, B+1, 0)); end
    checks++; if (bus.sum_cnt !== CW'(2)) begin errs++; $display("FAIL basic_cnt got=%0d want=2", bus.sum_cnt); end
    drain();
    checks++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL basic_drop got=%b want=0", bus.sum_valid); end
    checks++; if (bus.prod_ready !== 1'b1) begin errs++; $display("FAIL basic_ready got=%b want=1", bus.prod_ready); end
  endtask

  task automatic test_cancel();
    send(ONE5, 1'b0);
    send(mk(1, B, 64), 1'b1);
    checks++; if (bus.sum !== fp_t'('0)) begin errs++; $display("FAIL cancel_sum got=%h want=0", bus.sum); end
    checks++; if (bus.sum_cnt !== CW'(2)) begin errs++; $display("FAIL cancel_cnt got=%0d want=2", bus.sum_cnt); end
    drain();
  endtask

  task automatic test_mixed();
    send(TWO, 1'b0);
    send(mk(1, B-1, 0), 1'b0);
    send(mk(0, 0, 0), 1'b1);
    checks++; if (bus.sum !== ONE5) begin errs++; $display("FAIL mixed_sum got=%h want=%h", bus.sum, ONE5); end
    checks++; if (bus.sum_cnt !== CW'(3)) begin errs++; $display("FAIL mixed_cnt got=%0d want=3", bus.sum_cnt); end
    drain();
    // A zero with a nonzero mantissa in first position still acts as zero
    send(mk(0, 0, 5), 1'b0);
    send(ONE5, 1'b1);
    checks++; if (bus.sum !== ONE5) begin errs++; $display("FAIL zero_first got=%h want=%h", bus.sum, ONE5); end
    drain();
  endtask

  task automatic test_backpressure();
    send(ONE, 1'b0);
    send(ONE, 1'b1);
    // Upstream holds the next vector's only element throughout the stall
    bus.prod       = ONE5;
    bus.prod_valid = 1'b1;
    bus.prod_last  = 1'b1;
    bus.sum_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      checks++; if (bus.sum_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d] got=%b want=1", i, bus.sum_valid); end
      checks++; if (bus.sum !== TWO) begin errs++; $display("FAIL bp_sum[%0d] got=%h want=%h", i, bus.sum, TWO); end
      checks++; if (bus.sum_cnt !== CW'(2)) begin errs++; $display("FAIL bp_cnt[%0d] got=%0d want=2", i, bus.sum_cnt); end
      checks++; if (bus.prod_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d] got=%b want=0", i, bus.prod_ready); end
    end
    bus.sum_ready = 1'b1;
    @(posedge clk_i); #1;
    bus.sum_ready = 1'b0;
    checks++; if (bus.sum_valid !== 1'b0) begin errs++; $display("FAIL bp_one_hs got=%b want=0", bus.sum_valid); end
    checks++; if (bus.prod_ready !== 1'b1) begin errs++; $display("FAIL bp_rel_ready got=%b want=1", bus.prod_ready); end
    @(posedge clk_i); #1;
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    checks++; if (bus.sum_valid !== 1'b1) begin errs++; $display("FAIL bp_next_valid got=%b want=1", bus.sum_valid); end
    checks++; if (bus.sum !== ONE5) begin errs++; $display("FAIL bp_next_sum got=%h want=%h", bus.sum, ONE5); end
    checks++; if (bus.sum_cnt !== CW'(1)) begin errs++; $display("FAIL bp_next_cnt got=%0d want=1", bus.sum_cnt); end
    drain();
  endtask

  task automatic test_align_sat();
    send(ONE, 1'b0);
    send(mk(0, B-FPMantWidth-1, 0), 1'b1);
    checks++; if (bus.sum !== ONE) begin errs++; $display("FAIL align_sum got=%h want=%h", bus.sum, ONE); end
    drain();
    send(mk(0, 2**FPExpWidth-1, 0), 1'b0);
    send(mk(0, 2**FPExpWidth-1, 0), 1'b1);
    checks++; if (bus.sum !== mk(0, 2**FPExpWidth-1, 2**FPMantWidth-1)) begin errs++; $display("FAIL sat_pos got=%h want=%h", bus.sum, mk(0, 2**FPExpWidth-1, 2**FPMantWidth-1)); end
    drain();
    send(mk(1, 2**FPExpWidth-1, 3), 1'b0);
    send(mk(1, 2**FPExpWidth-1, 3), 1'b1);
    checks++; if (bus.sum !== mk(1, 2**FPExpWidth-1, 2**FPMantWidth-1)) begin errs++; $display("FAIL sat_neg got=%h want=%h", bus.sum, mk(1, 2**FPExpWidth-1, 2**FPMantWidth-1)); end
    drain();
  endtask

  task automatic test_count();
    // 259 ones: exact up to 256.0, then 256+1 truncates back to 256.0
    for (int i = 0; i < 2**CW + 3; i++) send(ONE, i == 2**CW + 2);
    checks++; if (bus.sum_cnt !== {CW{1'b1}}) begin errs++; $display("FAIL cnt_sat got=%0d want=%0d", bus.sum_cnt, 2**CW-1); end
    checks++; if (bus.sum !== mk(0, B+8, 0)) begin errs++; $display("FAIL cnt_sum got=%h want=%h", bus.sum, mk(0, B+8, 0)); end
    drain();
  endtask

  initial begin
    ONE  = mk(0, B, 0);
    ONE5 = mk(0, B, 64);
    TWO  = mk(0, B+1, 0);
    bus.prod       = '0;
    bus.prod_valid = 1'b0;
    bus.prod_last  = 1'b0;
    bus.sum_ready  = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_mixed();
    test_backpressure();
    test_align_sat();
    test_count();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
